combi_ckt: RTL and testbench
============================

COMBI_CKT -- requirements
Module: combi_ckt

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Parameter TT, default 16'hCDAD, SHALL be the truth table: bit i gives Y for input index i = {A,B,C,D}.
REQ-003 Parameter CNT_W, default 8, SHALL set the hit_cnt width; legal range 2..16.
REQ-004 Port clk SHALL be input, 1 bit: rising-edge clock for all registered outputs.
REQ-005 Port rst SHALL be input, 1 bit: synchronous active-high reset.
REQ-006 Ports A, B, C, D SHALL be inputs, 1 bit each: function inputs; A is MSB, D is LSB.
REQ-007 Port Y SHALL be output, 1 bit: combinational function result.
REQ-008 Port y_q SHALL be output, 1 bit: Y registered.
REQ-009 Port y_rise SHALL be output, 1 bit: one-cycle pulse on a registered 0->1 transition of Y.
REQ-010 Port hit_cnt SHALL be output, CNT_W bits: saturating count of clock edges sampled with Y=1.
REQ-011 Port declaration order SHALL be A, B, C, D, Y, clk, rst, y_q, y_rise, hit_cnt, so that positional 5-port instantiation (A,B,C,D,Y) stays legal.

Function
REQ-012 Y SHALL equal TT[{A,B,C,D}] combinationally, with zero latency and independent of clk and rst.
REQ-013 With the default TT, Y SHALL be 1 for indices 0,2,3,5,7,8,10,11,14,15 and 0 for indices 1,4,6,9,12,13.
- In full: 0000->1, 0001->0, 0010->1, 0011->1, 0100->0, 0101->1, 0110->0, 0111->1.
- 1000->1, 1001->0, 1010->1, 1011->1, 1100->0, 1101->0, 1110->1, 1111->1.
REQ-014 Y SHALL settle within the same time step as any input change, with no glitch-dependent state.
REQ-015 y_q SHALL take the value of Y sampled at each rising clk edge, giving one cycle of latency.
REQ-016 y_rise SHALL be 1 for exactly one cycle after an edge where the sampled Y=1 and the previous y_q=0; otherwise 0.
REQ-017 hit_cnt SHALL increment by 1 on each rising edge where Y=1 and rst=0.
REQ-018 hit_cnt SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-019 Any X or Z on A..D SHALL not be resolved by the design: Y follows simulator semantics and registers capture the result.

Reset
REQ-020 When rst=1 at a rising clk edge, the block SHALL set y_q=0, y_rise=0 and hit_cnt=0, regardless of Y.
REQ-021 rst SHALL not affect Y; Y stays combinational during reset.
REQ-022 On the first edge after rst deasserts with Y=1, the block SHALL set y_q=1, y_rise=1 and hit_cnt=1.
REQ-023 Reset asserted mid-count SHALL clear hit_cnt on that edge, with no increment on that edge.

Verification
REQ-024 Exhaustive sweep: drive all 16 {A,B,C,D} codes, 0000 to 1111, holding each 1 time unit -> Y matches REQ-013 on every code.
REQ-025 Latency check: with rst=0, drive 0100 (Y=0), then 0101 (Y=1) before an edge -> after that edge y_q=1 and y_rise=1; one cycle later y_rise=0.
REQ-026 Counting check: after reset, hold 1111 (Y=1) for 10 edges -> hit_cnt=10; then hold 0001 (Y=0) for 5 edges -> hit_cnt remains 10.
REQ-027 Saturation check: CNT_W=2, hold 0000 (Y=1) for 6 edges -> hit_cnt reads 1,2,3,3,3,3.
REQ-028 Reset-mid-operation check: with hit_cnt=5 and Y=1, assert rst for one edge -> y_q=0, y_rise=0, hit_cnt=0; Y remains 1 throughout.
REQ-029 Parameter check: TT=16'h0001 -> Y=1 only for 0000; TT=16'h8000 -> Y=1 only for 1111.

Source files
------------

// File: rtl/combi_ckt.sv
// rtl/combi_ckt.sv - 4-input truth-table function with registered output, rise pulse and saturating hit counter
module combi_ckt #(
    parameter logic [15:0] TT    = 16'hCDAD,
    parameter int          CNT_W = 8
) (
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             Y,
    input  logic             clk,
    input  logic             rst,
    output logic             y_q,
    output logic             y_rise,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0] idx;

    // A is the MSB of the table index, D the LSB
    assign idx = {A, B, C, D};
    assign Y   = TT[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= 1'b0;
            y_rise  <= 1'b0;
            hit_cnt <= '0;
        end else begin
            y_q    <= Y;
            y_rise <= Y & ~y_q;
            if (Y && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_combi_ckt.sv
// tb/tb_combi_ckt.sv - self-checking bench for combi_ckt
module tb_combi_ckt;

    logic       clk = 1'b0;
    logic       rst;
    logic       A, B, C, D;
    logic       Y, y_q, y_rise;
    logic [7:0] hit_cnt;
    logic       Y_s, y_q_s, y_rise_s;
    logic [1:0] hit_cnt_s;
    logic       Y_t1, y_q_t1, y_rise_t1;
    logic [7:0] hit_cnt_t1;
    logic       Y_t8, y_q_t8, y_rise_t8;
    logic [7:0] hit_cnt_t8;

    int errors = 0;
    int checks = 0;

    int m_yq, m_rise, m_cnt, m_sat;

    always #5 clk = ~clk;

    combi_ckt dut (
        .A(A), .B(B), .C(C), .D(D), .Y(Y), .clk(clk), .rst(rst),
        .y_q(y_q), .y_rise(y_rise), .hit_cnt(hit_cnt)
    );

    combi_ckt #(.CNT_W(2)) dut_sat (
        .A(A), .B(B), .C(C), .D(D), .Y(Y_s), .clk(clk), .rst(rst),
        .y_q(y_q_s), .y_rise(y_rise_s), .hit_cnt(hit_cnt_s)
    );

    combi_ckt #(.TT(16'h0001)) dut_t1 (
        .A(A), .B(B), .C(C), .D(D), .Y(Y_t1), .clk(clk), .rst(rst),
        .y_q(y_q_t1), .y_rise(y_rise_t1), .hit_cnt(hit_cnt_t1)
    );

    combi_ckt #(.TT(16'h8000)) dut_t8 (
        .A(A), .B(B), .C(C), .D(D), .Y(Y_t8), .clk(clk), .rst(rst),
        .y_q(y_q_t8), .y_rise(y_rise_t8), .hit_cnt(hit_cnt_t8)
    );

    function automatic int ref_y(input int code);
        return (code inside {0, 2, 3, 5, 7, 8, 10, 11, 14, 15}) ? 1 : 0;
    endfunction

    function automatic int cur_code();
        return {A, B, C, D};
    endfunction

    task automatic drive(input int code);
        A = code[3];
        B = code[2];
        C = code[1];
        D = code[0];
    endtask

    // advance one rising edge and update the reference model with what was sampled
    task automatic step();
        int y;
        @(posedge clk);
        y = ref_y(cur_code());
        if (rst) begin
            m_yq = 0; m_rise = 0; m_cnt = 0; m_sat = 0;
        end else begin
            m_rise = (y == 1 && m_yq == 0) ? 1 : 0;
            m_yq   = y;
            if (y == 1) begin
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_sat = (m_sat < 3) ? m_sat + 1 : 3;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(4'b1111);
        do_reset();
        checks++;
        if (y_q !== 1'b0 || y_rise !== 1'b0 || hit_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset: y_q=%b y_rise=%b hit_cnt=%0d, required 0 0 0", y_q, y_rise, hit_cnt);
        end
        checks++;
        if (hit_cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL reset_sat: hit_cnt=%0d, required 0", hit_cnt_s);
        end
        checks++;
        if (Y !== 1'b1) begin
            errors++;
            $display("FAIL reset_y_comb: Y=%b, required 1", Y);
        end
    endtask

    task automatic test_sweep();
        for (int c = 0; c < 16; c++) begin
            drive(c);
            #1;
            checks++;
            if (Y !== 1'(ref_y(c))) begin
                errors++;
                $display("FAIL sweep code=%0d: Y=%b, required %0d", c, Y, ref_y(c));
            end
            checks++;
            if (Y_t1 !== (c == 0)) begin
                errors++;
                $display("FAIL tt_0001 code=%0d: Y=%b, required %0d", c, Y_t1, (c == 0));
            end
            checks++;
            if (Y_t8 !== (c == 15)) begin
                errors++;
                $display("FAIL tt_8000 code=%0d: Y=%b, required %0d", c, Y_t8, (c == 15));
            end
        end
    endtask

    task automatic test_latency();
        do_reset();
        drive(4'b0100);
        step();
        checks++;
        if (y_q !== 1'b0 || y_rise !== 1'b0) begin
            errors++;
            $display("FAIL latency_pre: y_q=%b y_rise=%b, required 0 0", y_q, y_rise);
        end
        drive(4'b0101);
        step();
        checks++;
        if (y_q !== 1'b1 || y_rise !== 1'b1) begin
            errors++;
            $display("FAIL latency_edge: y_q=%b y_rise=%b, required 1 1", y_q, y_rise);
        end
        step();
        checks++;
        if (y_q !== 1'b1 || y_rise !== 1'b0) begin
            errors++;
            $display("FAIL latency_next: y_q=%b y_rise=%b, required 1 0", y_q, y_rise);
        end
    endtask

    task automatic test_count();
        drive(4'b0001);
        do_reset();
        drive(4'b1111);
        repeat (10) step();
        checks++;
        if (hit_cnt !== 8'd10) begin
            errors++;
            $display("FAIL count_hold1: hit_cnt=%0d, required 10", hit_cnt);
        end
        drive(4'b0001);
        repeat (5) step();
        checks++;
        if (hit_cnt !== 8'd10) begin
            errors++;
            $display("FAIL count_hold0: hit_cnt=%0d, required 10", hit_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_seq [6] = '{1, 2, 3, 3, 3, 3};
        drive(4'b0001);
        do_reset();
        drive(4'b0000);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (hit_cnt_s !== 2'(exp_seq[i])) begin
                errors++;
                $display("FAIL saturation edge %0d: hit_cnt=%0d, required %0d", i + 1, hit_cnt_s, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(4'b0001);
        do_reset();
        drive(4'b1111);
        repeat (5) step();
        checks++;
        if (hit_cnt !== 8'd5) begin
            errors++;
            $display("FAIL reset_mid_pre: hit_cnt=%0d, required 5", hit_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (Y !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_y_during: Y=%b, required 1", Y);
        end
        step();
        checks++;
        if (y_q !== 1'b0 || y_rise !== 1'b0 || hit_cnt !== 8'd0 || Y !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: y_q=%b y_rise=%b hit_cnt=%0d Y=%b, required 0 0 0 1",
                     y_q, y_rise, hit_cnt, Y);
        end
        rst = 1'b0;
        step();
        checks++;
        if (y_q !== 1'b1 || y_rise !== 1'b1 || hit_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reset_release: y_q=%b y_rise=%b hit_cnt=%0d, required 1 1 1", y_q, y_rise, hit_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(int'($urandom_range(0, 15)));
            rst = ($urandom_range(0, 29) == 0);
            #1;
            checks++;
            if (Y !== 1'(ref_y(cur_code()))) begin
                errors++;
                $display("FAIL random_y iter=%0d: Y=%b, required %0d", i, Y, ref_y(cur_code()));
            end
            step();
            checks++;
            if (y_q !== 1'(m_yq) || y_rise !== 1'(m_rise) || hit_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL random_regs iter=%0d: y_q=%b y_rise=%b hit_cnt=%0d, required %0d %0d %0d",
                         i, y_q, y_rise, hit_cnt, m_yq, m_rise, m_cnt);
            end
            checks++;
            if (hit_cnt_s !== 2'(m_sat)) begin
                errors++;
                $display("FAIL random_sat iter=%0d: hit_cnt=%0d, required %0d", i, hit_cnt_s, m_sat);
            end
        end
        rst = 1'b0;
        drive(4'b1111);
        repeat (300) step();
        checks++;
        if (hit_cnt !== 8'(m_cnt) || m_cnt != 255) begin
            errors++;
            $display("FAIL random_long_sat: hit_cnt=%0d model=%0d, required 255", hit_cnt, m_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_yq = 0; m_rise = 0; m_cnt = 0; m_sat = 0;
        drive(4'b0000);
        #2;
        test_reset();
        test_sweep();
        test_latency();
        test_count();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
